// File: rtl/uart_rx_loopback_buf.sv
// Loopback buffer between the UART receive and transmit sides: received bytes are queued
// in a circular RAM and replayed in order through a prefetching valid/ready output register.
module uart_rx_loopback_buf #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_FIFO_DEPTH = 16,
   parameter int P_ADDR_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    w_user_rst,
   input  logic [P_DATA_WIDTH-1:0] i_rx_data,
   input  logic                    i_rx_valid,
   output logic [P_DATA_WIDTH-1:0] o_tx_data,
   output logic                    o_tx_valid,
   input  logic                    i_tx_ready,
   output logic [P_ADDR_WIDTH:0]   o_fifo_count,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_overflow,
   input  logic                    i_clear_overflow
);

   localparam logic [P_ADDR_WIDTH:0]   L_CNT_FULL = (P_ADDR_WIDTH+1)'(P_FIFO_DEPTH);
   localparam logic [P_ADDR_WIDTH:0]   L_CNT_ONE  = (P_ADDR_WIDTH+1)'(1);
   localparam logic [P_ADDR_WIDTH-1:0] L_PTR_ONE  = P_ADDR_WIDTH'(1);

   logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];

   logic [P_ADDR_WIDTH-1:0] wp_q, wp_d;
   logic [P_ADDR_WIDTH-1:0] rp_q, rp_d;
   logic [P_ADDR_WIDTH:0]   count_q, count_d;
   logic                    tx_valid_q, tx_valid_d;
   logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                    overflow_q, overflow_d;

   logic full, empty, wr_en, drop, hs, load;

   always_comb begin
      full  = (count_q == L_CNT_FULL);
      empty = (count_q == '0);
      // Full is judged on the pre-edge count, so a same-edge pop never rescues a byte.
      wr_en = i_rx_valid & ~full;
      drop  = i_rx_valid & full;
      hs    = tx_valid_q & i_tx_ready;
      load  = (~tx_valid_q | hs) & ~empty;

      wp_d = wr_en ? wp_q + L_PTR_ONE : wp_q;
      rp_d = load  ? rp_q + L_PTR_ONE : rp_q;

      count_d = count_q;
      if (wr_en && !load) begin
         count_d = count_q + L_CNT_ONE;
      end else if (load && !wr_en) begin
         count_d = count_q - L_CNT_ONE;
      end

      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      if (load) begin
         tx_valid_d = 1'b1;
         tx_data_d  = mem_q[rp_q];
      end else if (hs) begin
         tx_valid_d = 1'b0;
      end

      // A drop on the same edge as a clear leaves the flag set.
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (i_clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge w_user_rst) begin
      if (w_user_rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
      end
   end

   // RAM contents are don't-care after reset; only the pointers define what is stored.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wp_q] <= i_rx_data;
      end
   end

   assign o_tx_data    = tx_data_q;
   assign o_tx_valid   = tx_valid_q;
   assign o_fifo_count = count_q;
   assign o_full       = full;
   assign o_empty      = empty;
   assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_loopback_buf.sv
// Bench for uart_rx_loopback_buf: a per-cycle reference model with a byte scoreboard,
// a table-driven single-byte check and hand-written multi-cycle sequences.
module tb_uart_rx_loopback_buf;

   localparam int W = 8;
   localparam int D = 16;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         w_user_rst = 1'b0;
   logic [W-1:0] i_rx_data = '0;
   logic         i_rx_valid = 1'b0;
   logic [W-1:0] o_tx_data;
   logic         o_tx_valid;
   logic         i_tx_ready = 1'b0;
   logic [A:0]   o_fifo_count;
   logic         o_full, o_empty, o_overflow;
   logic         i_clear_overflow = 1'b0;

   int checks   = 0;
   int failures = 0;
   int hs_cnt   = 0;

   always #5 clk = ~clk;

   uart_rx_loopback_buf #(.P_DATA_WIDTH(W), .P_FIFO_DEPTH(D), .P_ADDR_WIDTH(A)) dut (
      .clk              (clk),
      .w_user_rst       (w_user_rst),
      .i_rx_data        (i_rx_data),
      .i_rx_valid       (i_rx_valid),
      .o_tx_data        (o_tx_data),
      .o_tx_valid       (o_tx_valid),
      .i_tx_ready       (i_tx_ready),
      .o_fifo_count     (o_fifo_count),
      .o_full           (o_full),
      .o_empty          (o_empty),
      .o_overflow       (o_overflow),
      .i_clear_overflow (i_clear_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: RAM occupancy, output-register valid and sticky overflow.
   logic [A:0]   m_cnt;
   logic         m_vld, m_ovf;
   logic [W-1:0] sb [$];
   logic         m_full, m_wr, m_hs, m_ld;

   assign m_full = (m_cnt == (A+1)'(D));
   assign m_wr   = i_rx_valid && !m_full;
   assign m_hs   = m_vld && i_tx_ready;
   assign m_ld   = (!m_vld || m_hs) && (m_cnt != '0);

   always @(posedge clk or posedge w_user_rst) begin
      if (w_user_rst) begin
         m_cnt <= '0;
         m_vld <= 1'b0;
         m_ovf <= 1'b0;
         sb.delete();
      end else begin
         if (m_wr) sb.push_back(i_rx_data);
         m_cnt <= m_cnt + (A+1)'(m_wr) - (A+1)'(m_ld);
         if (m_ld) m_vld <= 1'b1;
         else if (m_hs) m_vld <= 1'b0;
         if (i_rx_valid && m_full) m_ovf <= 1'b1;
         else if (i_clear_overflow) m_ovf <= 1'b0;
      end
   end

   // Monitor on the falling edge: status against the model, handshakes against the scoreboard.
   logic         prev_vld, prev_rdy;
   logic [W-1:0] prev_data;

   always @(negedge clk or posedge w_user_rst) begin
      if (w_user_rst) begin
         prev_vld  <= 1'b0;
         prev_rdy  <= 1'b0;
         prev_data <= '0;
      end else begin
         check("count", o_fifo_count, m_cnt);
         check("tx_valid", o_tx_valid, m_vld);
         check("overflow", o_overflow, m_ovf);
         check("full", o_full, m_cnt == (A+1)'(D));
         check("empty", o_empty, m_cnt == '0);
         if (prev_vld && !prev_rdy) check("stall_stable", o_tx_data, prev_data);
         if (o_tx_valid && i_tx_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_byte", o_tx_data, 32'hFFFF_FFFF);
            end else begin
               check("tx_data_order", o_tx_data, sb.pop_front());
               hs_cnt++;
            end
         end
         prev_vld  <= o_tx_valid;
         prev_rdy  <= i_tx_ready;
         prev_data <= o_tx_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [W-1:0] b);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int bound, input bit toggle);
      int n = 0;
      while ((sb.size() != 0 || o_tx_valid) && n < bound) begin
         i_tx_ready = toggle ? ~i_tx_ready : 1'b1;
         tick();
         n++;
      end
      check(name, (sb.size() == 0) && !o_tx_valid, 1);
   endtask

   typedef struct {
      logic         rxv;
      logic [W-1:0] rxd;
      logic         rdy;
      logic         ev;
      logic [W-1:0] ed;
      logic [A:0]   ec;
      logic         ee;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int base;
      vecs[0] = '{rxv: 1'b1, rxd: 8'hA5, rdy: 1'b1, ev: 1'b0, ed: 8'h00, ec: 5'd1, ee: 1'b0};
      vecs[1] = '{rxv: 1'b0, rxd: 8'h00, rdy: 1'b1, ev: 1'b1, ed: 8'hA5, ec: 5'd0, ee: 1'b1};
      vecs[2] = '{rxv: 1'b0, rxd: 8'h00, rdy: 1'b1, ev: 1'b0, ed: 8'hA5, ec: 5'd0, ee: 1'b1};
      vecs[3] = '{rxv: 1'b0, rxd: 8'h00, rdy: 1'b1, ev: 1'b0, ed: 8'hA5, ec: 5'd0, ee: 1'b1};

      #1 w_user_rst = 1'b1;
      #2;
      check("rst_valid", o_tx_valid, 0);
      check("rst_data", o_tx_data, 0);
      check("rst_count", o_fifo_count, 0);
      check("rst_empty", o_empty, 1);
      check("rst_full", o_full, 0);
      check("rst_ovf", o_overflow, 0);
      @(posedge clk);
      #1 w_user_rst = 1'b0;
      tick();

      // Single byte through the table.
      for (int i = 0; i < 4; i++) begin
         i_rx_valid = vecs[i].rxv;
         i_rx_data  = vecs[i].rxd;
         i_tx_ready = vecs[i].rdy;
         tick();
         check($sformatf("vec%0d_valid", i), o_tx_valid, vecs[i].ev);
         check($sformatf("vec%0d_data", i), o_tx_data, vecs[i].ed);
         check($sformatf("vec%0d_count", i), o_fifo_count, vecs[i].ec);
         check($sformatf("vec%0d_empty", i), o_empty, vecs[i].ee);
      end
      i_rx_valid = 1'b0;

      // Burst into a stalled sink, then an overflowing byte, then drain.
      i_tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) write_byte(8'(i));
      check("burst_data", o_tx_data, 8'h00);
      check("burst_valid", o_tx_valid, 1);
      check("burst_count", o_fifo_count, 16);
      check("burst_full", o_full, 1);
      check("burst_ovf", o_overflow, 0);
      write_byte(8'h11);
      check("burst_drop_ovf", o_overflow, 1);
      check("burst_drop_count", o_fifo_count, 16);
      base = hs_cnt;
      i_tx_ready = 1'b1;
      repeat (17) tick();
      check("burst_drained_valid", o_tx_valid, 0);
      check("burst_hs_count", hs_cnt - base, 17);
      check("burst_sb_empty", sb.size(), 0);
      i_clear_overflow = 1'b1;
      tick();
      i_clear_overflow = 1'b0;
      check("clear_ovf", o_overflow, 0);

      // Ready toggling every cycle while bytes arrive.
      base = hs_cnt;
      i_tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         i_tx_ready = i[0];
         write_byte(8'h31 + 8'(i));
      end
      wait_drain("stall_drain", 40, 1'b1);
      check("stall_hs_count", hs_cnt - base, 4);

      // Wrap-around: 40 bytes spaced two cycles apart.
      base = hs_cnt;
      i_tx_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         write_byte(8'(i));
         tick();
      end
      wait_drain("wrap_drain", 20, 1'b0);
      check("wrap_hs_count", hs_cnt - base, 40);
      check("wrap_ovf", o_overflow, 0);

      // Same-edge pop and write while full; clear against drop; clear alone.
      base = hs_cnt;
      i_tx_ready = 1'b0;
      for (int i = 0; i < 17; i++) write_byte(8'h80 + 8'(i));
      check("sim_fill_count", o_fifo_count, 16);
      i_tx_ready = 1'b1;
      write_byte(8'hEE);
      i_tx_ready = 1'b0;
      check("sim_pop_write_ovf", o_overflow, 1);
      check("sim_pop_write_count", o_fifo_count, 15);
      write_byte(8'hEF);
      check("sim_refill_count", o_fifo_count, 16);
      i_clear_overflow = 1'b1;
      write_byte(8'hF0);
      check("sim_clear_vs_drop", o_overflow, 1);
      tick();
      i_clear_overflow = 1'b0;
      check("sim_clear_alone", o_overflow, 0);
      wait_drain("sim_drain", 40, 1'b0);
      check("sim_hs_count", hs_cnt - base, 18);

      // Reset between edges while bytes are held.
      i_tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) write_byte(8'h40 + 8'(i));
      check("pre_rst_count", o_fifo_count, 5);
      check("pre_rst_valid", o_tx_valid, 1);
      #1 w_user_rst = 1'b1;
      #1;
      check("mid_rst_valid", o_tx_valid, 0);
      check("mid_rst_count", o_fifo_count, 0);
      check("mid_rst_empty", o_empty, 1);
      w_user_rst = 1'b0;
      tick();
      base = hs_cnt;
      i_tx_ready = 1'b1;
      write_byte(8'h5A);
      wait_drain("post_rst_drain", 10, 1'b0);
      check("post_rst_hs_count", hs_cnt - base, 1);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_rx_loopback_buf.md
Name: uart_rx_loopback_buf

Overview:
- Sits between the UART driver's receive side and its transmit side, in the user clock domain.
- Captures each received byte (single-cycle valid pulse) into a circular FIFO.
- Replays the stored bytes, in order, on a valid/ready transmit handshake.
- Provides burst absorption for loopback/echo builds, plus occupancy and sticky overflow status.

Parameters:
- P_DATA_WIDTH, 8, width of one UART data byte/word
- P_FIFO_DEPTH, 16, number of RAM entries; must be a power of two, at least 2
- P_ADDR_WIDTH, 4, log2(P_FIFO_DEPTH)

Ports:
- clk  in  1  user clock (UART driver user clock)
- w_user_rst  in  1  asynchronous reset, active-high
- i_rx_data  in  P_DATA_WIDTH  received byte; valid only while i_rx_valid=1
- i_rx_valid  in  1  one-cycle strobe per received byte
- o_tx_data  out  P_DATA_WIDTH  byte offered to the UART transmitter
- o_tx_valid  out  1  o_tx_data is valid
- i_tx_ready  in  1  transmitter accepts o_tx_data when o_tx_valid=1 on the same edge
- o_fifo_count  out  P_ADDR_WIDTH+1  entries held in RAM, excluding the output register
- o_full  out  1  o_fifo_count == P_FIFO_DEPTH
- o_empty  out  1  o_fifo_count == 0
- o_overflow  out  1  sticky: a byte was dropped
- i_clear_overflow  in  1  one-cycle strobe that clears o_overflow

Behaviour:
- Reset (asynchronous, active-high w_user_rst; clock clk):
  - Pointers and count go to 0; o_tx_valid=0, o_tx_data=0, o_empty=1, o_full=0, o_overflow=0.
  - RAM contents are don't-care.
  - Reset asserted mid-transfer discards all stored bytes and the output register immediately; no partial state survives.
- Storage:
  - RAM of P_FIFO_DEPTH x P_DATA_WIDTH, with write pointer wp and read pointer rp, each P_ADDR_WIDTH bits.
  - Pointers wrap naturally from P_FIFO_DEPTH-1 to 0.
  - o_fifo_count is a separate registered counter.
  - Total capacity = P_FIFO_DEPTH + 1 (RAM plus the output register).
- Write: on an edge with i_rx_valid=1 and o_full=0, store i_rx_data at wp, then wp+1 and count+1.
- Drop:
  - On an edge with i_rx_valid=1 and o_full=1, the byte is discarded and o_overflow is set to 1.
  - Full is judged on the pre-edge state: a pop on the same edge does not rescue the byte.
- Output register (prefetch stage):
  - Handshake hs = o_tx_valid & i_tx_ready.
  - Load condition: (o_tx_valid=0 or hs=1) and o_empty=0.
  - When the load condition is true, o_tx_data <= RAM[rp], rp+1, count-1, o_tx_valid <= 1.
  - Else if hs=1, o_tx_valid <= 0.
  - Else o_tx_valid and o_tx_data hold; data must stay stable while valid=1 and ready=0.
- Simultaneous write and load on one edge: count is unchanged, and both pointers advance.
- Latency:
  - i_rx_valid sampled at edge N with the block fully empty gives o_tx_valid=1 after edge N+1.
  - There is no write-to-output bypass.
- Throughput: back-to-back handshakes are sustained at one byte per cycle while RAM is non-empty.
- Overflow flag:
  - i_clear_overflow=1 clears o_overflow.
  - If a drop occurs on the same edge as a clear, the set wins and o_overflow stays 1.
- Status timing: o_full and o_empty are decoded from the registered count, with no extra latency.
- i_tx_ready is ignored while o_tx_valid=0.

Test Plan:
- Single byte: reset, then i_rx_valid pulse with 0xA5, i_tx_ready=1 held -> o_tx_valid rises 2 edges after the strobe with 0xA5, falls on the next edge; o_fifo_count returns to 0 and o_empty=1.
- Burst with a stalled sink: i_tx_ready=0, write 0x00..0x10 (17 bytes) -> output register holds 0x00, o_fifo_count=16, o_full=1, o_overflow=0. An 18th byte 0x11 -> o_overflow=1, count stays 16. Then ready=1 -> bytes 0x00..0x10 emerge in order, one per cycle, and 0x11 never appears.
- Stall stability: valid=1, ready toggling 0/1 every cycle across 4 bytes 0x31..0x34 -> each byte is emitted exactly once, o_tx_data is unchanged while ready=0, and order is preserved.
- Wrap-around: 40 bytes 0x00..0x27 written 2 cycles apart with ready=1 throughout -> output sequence 0x00..0x27 with no loss; pointers wrap twice and o_overflow=0.
- Simultaneous events:
  - Count 16 with a pop and a write on the same edge -> write dropped, o_overflow=1.
  - Clear and drop on the same edge -> o_overflow stays 1.
  - Clear alone -> o_overflow=0.
- Reset mid-operation: with count=5 and valid=1, pulse w_user_rst between clock edges -> o_tx_valid=0, o_fifo_count=0, o_empty=1 immediately. A new byte 0x5A after release -> output is 0x5A only.
